// File: rtl/ad9643_spi_master.sv
// AD9643 3-wire SPI master: one 24-bit frame {rw, W1W0=00, addr[12:0], data[7:0]} per command.
// Define AD9643_SPI_AUTO_TRANSFER_EN to chain a transfer-bit write (0x0FF <= 0x01) after each write.
module ad9643_spi_master #(
    parameter int CLK_DIV = 2,
    parameter int CSB_GAP = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic [12:0] cmd_addr,
    input  logic [7:0]  cmd_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        sclk,
    output logic        csb,
    output logic        sdio_o,
    output logic        sdio_oe,
    input  logic        sdio_i
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CSB_GAP > 1) ? $clog2(CSB_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CSB_GAP - 1);
    // half_cnt counts sclk half-periods: odd halves are sclk high, bit k spans halves 2k-2..2k-1
    localparam logic [5:0] HALF_TURN   = 6'd31;  // leaving it = falling edge 16
    localparam logic [5:0] HALF_SAMPLE = 6'd32;  // leaving it = rising edge 17
    localparam logic [5:0] HALF_LAST   = 6'd47;  // leaving it = falling edge 24

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       half_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [23:0]      shreg;
    logic [7:0]       rd_sh;
    logic             is_read;
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
    logic             chain;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            half_cnt  <= '0;
            gap_cnt   <= '0;
            shreg     <= '0;
            rd_sh     <= '0;
            is_read   <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            sclk      <= 1'b0;
            csb       <= 1'b1;
            sdio_o    <= 1'b0;
            sdio_oe   <= 1'b0;
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
            chain     <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        shreg     <= {cmd_rw, 2'b00, cmd_addr, cmd_wdata};
                        is_read   <= cmd_rw;
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
                        chain     <= !cmd_rw && (cmd_addr != 13'h0FF);
`endif
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        csb       <= 1'b0;
                        sclk      <= 1'b0;
                        sdio_oe   <= 1'b1;
                        sdio_o    <= cmd_rw;
                        div_cnt   <= '0;
                        half_cnt  <= '0;
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        half_cnt <= half_cnt + 6'd1;
                        if (!half_cnt[0]) begin
                            sclk <= 1'b1;
                            if (half_cnt >= HALF_SAMPLE)
                                rd_sh <= {rd_sh[6:0], sdio_i};
                        end else begin
                            sclk <= 1'b0;
                            if (half_cnt == HALF_LAST) begin
                                state <= HOLD;
                            end else begin
                                shreg <= {shreg[22:0], 1'b0};
                                // Reads hand SDIO to the ADC for the data byte
                                if (is_read && half_cnt >= HALF_TURN) begin
                                    sdio_oe <= 1'b0;
                                    sdio_o  <= 1'b0;
                                end else begin
                                    sdio_o  <= shreg[22];
                                end
                            end
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                HOLD: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        csb     <= 1'b1;
                        sdio_oe <= 1'b0;
                        sdio_o  <= 1'b0;
                        gap_cnt <= '0;
                        state   <= GAP;
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
                        if (!chain) begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= is_read ? rd_sh : 8'h00;
                        end
`else
                        rsp_valid <= 1'b1;
                        rsp_rdata <= is_read ? rd_sh : 8'h00;
`endif
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
                        if (chain) begin
                            // Commit the staged write by setting the transfer bit
                            chain    <= 1'b0;
                            is_read  <= 1'b0;
                            shreg    <= {1'b0, 2'b00, 13'h0FF, 8'h01};
                            csb      <= 1'b0;
                            sclk     <= 1'b0;
                            sdio_oe  <= 1'b1;
                            sdio_o   <= 1'b0;
                            div_cnt  <= '0;
                            half_cnt <= '0;
                            state    <= SHIFT;
                        end else begin
                            cmd_ready <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
`else
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`endif
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9643_spi_master.sv
// Self-checking bench for ad9643_spi_master: two instances (CLK_DIV=2 and CLK_DIV=1) with an SPI responder model.
`timescale 1ns/1ps
module tb_ad9643_spi_master;

    localparam int CSB_GAP = 4;
    localparam int DIV [2] = '{2, 1};
`ifdef AD9643_SPI_AUTO_TRANSFER_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic        cmd_rw    [2];
    logic [12:0] cmd_addr  [2];
    logic [7:0]  cmd_wdata [2];
    logic        rsp_valid [2];
    logic [7:0]  rsp_rdata [2];
    logic        busy      [2];
    logic        sclk      [2];
    logic        csb       [2];
    logic        sdio_o    [2];
    logic        sdio_oe   [2];
    logic        sdio_i    [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ad9643_spi_master #(.CLK_DIV(2), .CSB_GAP(CSB_GAP)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_rw(cmd_rw[0]),
        .cmd_addr(cmd_addr[0]), .cmd_wdata(cmd_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
        .sclk(sclk[0]), .csb(csb[0]), .sdio_o(sdio_o[0]), .sdio_oe(sdio_oe[0]), .sdio_i(sdio_i[0])
    );

    ad9643_spi_master #(.CLK_DIV(1), .CSB_GAP(CSB_GAP)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_rw(cmd_rw[1]),
        .cmd_addr(cmd_addr[1]), .cmd_wdata(cmd_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
        .sclk(sclk[1]), .csb(csb[1]), .sdio_o(sdio_o[1]), .sdio_oe(sdio_oe[1]), .sdio_i(sdio_i[1])
    );

    // SPI responder: records MOSI bits on sclk rises, returns slave_byte after falling edges 16..23
    int          cyc = 0;
    logic        sclk_q     [2];
    logic        csb_q      [2];
    int          rise_cnt   [2];
    int          fall_cnt   [2];
    int          last_rise  [2];
    int          period_bad [2];
    int          oe_bad     [2];
    int          frame_cnt  [2];
    logic [23:0] shin       [2];
    logic [23:0] frame_log  [2][8];
    logic [7:0]  slave_byte [2];
    logic        read_mode  [2];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            sclk_q[i] <= sclk[i];
            csb_q[i]  <= csb[i];
            if (!rst_n) begin
                rise_cnt[i] <= 0;
                fall_cnt[i] <= 0;
                shin[i]     <= '0;
                sdio_i[i]   <= 1'b0;
            end else if (csb_q[i] && !csb[i]) begin
                rise_cnt[i] <= 0;
                fall_cnt[i] <= 0;
                shin[i]     <= '0;
            end else if (!csb[i]) begin
                if (sclk[i] && !sclk_q[i]) begin
                    rise_cnt[i]  <= rise_cnt[i] + 1;
                    last_rise[i] <= cyc;
                    shin[i]      <= {shin[i][22:0], sdio_oe[i] & sdio_o[i]};
                    if (rise_cnt[i] > 0 && (cyc - last_rise[i]) != 2 * DIV[i])
                        period_bad[i] <= period_bad[i] + 1;
                    if (rise_cnt[i] >= 16 && read_mode[i] && sdio_oe[i] !== 1'b0)
                        oe_bad[i] <= oe_bad[i] + 1;
                    if (rise_cnt[i] == 23) begin
                        frame_log[i][3'(frame_cnt[i])] <= {shin[i][22:0], sdio_oe[i] & sdio_o[i]};
                        frame_cnt[i] <= frame_cnt[i] + 1;
                    end
                end
                if (!sclk[i] && sclk_q[i]) begin
                    fall_cnt[i] <= fall_cnt[i] + 1;
                    if (fall_cnt[i] >= 15 && fall_cnt[i] <= 22)
                        sdio_i[i] <= slave_byte[i][3'(22 - fall_cnt[i])];
                end
            end
        end
    end

    task automatic wait_ready(input int i, input string name);
        int t;
        t = 0;
        while (cmd_ready[i] !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (cmd_ready[i] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait got %b want 1", name, cmd_ready[i]);
        end
    endtask

    // One command, checked against the frame/timing rules computed here
    task automatic run_cmd(input int i, input bit rw, input logic [12:0] addr,
                           input logic [7:0] wdata, input logic [7:0] sbyte, input string name);
        int          n_exp, f0, pb0, ob0, low, pulses, lat, bsy_bad, d;
        logic [7:0]  rd, exp_rd;
        logic [23:0] exp_f [2];
        logic [23:0] got;
        d        = DIV[i];
        n_exp    = (AUTO && !rw && addr != 13'h0FF) ? 2 : 1;
        exp_f[0] = {rw, 2'b00, addr, rw ? 8'h00 : wdata};
        exp_f[1] = 24'h00FF01;
        exp_rd   = rw ? sbyte : 8'h00;
        slave_byte[i] = sbyte;
        read_mode[i]  = rw;
        wait_ready(i, name);
        f0  = frame_cnt[i];
        pb0 = period_bad[i];
        ob0 = oe_bad[i];
        cmd_valid[i] = 1'b1;
        cmd_rw[i]    = rw;
        cmd_addr[i]  = addr;
        cmd_wdata[i] = wdata;
        @(negedge clk);
        cmd_valid[i] = 1'b0;
        cmd_rw[i]    = 1'($urandom_range(0, 1));
        cmd_addr[i]  = 13'($urandom_range(0, 8191));
        cmd_wdata[i] = 8'($urandom_range(0, 255));
        low = 0; pulses = 0; lat = 0; bsy_bad = 0; rd = 8'h00;
        for (int c = 0; c < 1000; c++) begin
            if (csb[i] === 1'b0) low++;
            if (rsp_valid[i] === 1'b1) begin
                pulses++;
                rd = rsp_rdata[i];
            end
            if (busy[i] !== ~cmd_ready[i]) bsy_bad++;
            if (cmd_ready[i] === 1'b1) begin
                lat = c + 1;
                break;
            end
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (lat != n_exp * (49 * d + CSB_GAP) + 1) begin
            errors++;
            $display("FAIL %s latency got %0d want %0d", name, lat, n_exp * (49 * d + CSB_GAP) + 1);
        end
        checks++;
        if (low != n_exp * 49 * d) begin
            errors++;
            $display("FAIL %s csb_low got %0d want %0d", name, low, n_exp * 49 * d);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL %s rsp_pulses got %0d want 1", name, pulses);
        end
        checks++;
        if (rd !== exp_rd) begin
            errors++;
            $display("FAIL %s rsp_rdata got %h want %h", name, rd, exp_rd);
        end
        checks++;
        if (rsp_rdata[i] !== exp_rd) begin
            errors++;
            $display("FAIL %s rdata_hold got %h want %h", name, rsp_rdata[i], exp_rd);
        end
        checks++;
        if (frame_cnt[i] - f0 != n_exp) begin
            errors++;
            $display("FAIL %s frame_count got %0d want %0d", name, frame_cnt[i] - f0, n_exp);
        end
        for (int k = 0; k < n_exp; k++) begin
            got = frame_log[i][3'(f0 + k)];
            checks++;
            if (got !== exp_f[k]) begin
                errors++;
                $display("FAIL %s frame%0d got %h want %h", name, k, got, exp_f[k]);
            end
        end
        checks++;
        if (period_bad[i] != pb0 || oe_bad[i] != ob0 || bsy_bad != 0) begin
            errors++;
            $display("FAIL %s sclk_period/oe/busy errors got %0d/%0d/%0d want 0/0/0",
                     name, period_bad[i] - pb0, oe_bad[i] - ob0, bsy_bad);
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            obs = {csb[i], sclk[i], sdio_o[i], sdio_oe[i], cmd_ready[i], busy[i], rsp_valid[i], rsp_rdata[i]};
            checks++;
            if (obs !== 15'b1_0_0_0_1_0_0_00000000) begin
                errors++;
                $display("FAIL reset_state%0d got %b want %b", i, obs, 15'b1_0_0_0_1_0_0_00000000);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (cmd_ready[i] !== 1'b1 || csb[i] !== 1'b1 || busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle%0d got ready=%b csb=%b busy=%b want 1 1 0",
                         i, cmd_ready[i], csb[i], busy[i]);
            end
        end
    endtask

    task automatic test_write();
        run_cmd(0, 1'b0, 13'h014, 8'h05, 8'h00, "write_014");
        run_cmd(0, 1'b0, 13'h1FFF, 8'hFF, 8'h00, "write_max");
        run_cmd(0, 1'b0, 13'h000, 8'h00, 8'h00, "write_zero");
        for (int n = 0; n < 3; n++)
            run_cmd(0, 1'b0, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)), 8'h00, "write_rand");
    endtask

    task automatic test_read();
        run_cmd(0, 1'b1, 13'h001, 8'h00, 8'h82, "read_001");
        run_cmd(0, 1'b1, 13'($urandom_range(0, 8191)), 8'h00, 8'hFF, "read_ff");
        run_cmd(0, 1'b1, 13'($urandom_range(0, 8191)), 8'h00, 8'h00, "read_00");
        for (int n = 0; n < 3; n++)
            run_cmd(0, 1'b1, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), "read_rand");
        run_cmd(0, 1'b0, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)), 8'h00, "write_after_read");
    endtask

    task automatic test_back_to_back();
        logic [12:0] a [3];
        logic [7:0]  dt [3];
        logic [23:0] exp_fr [$];
        int          exp_gap [$];
        int          obs_gap [$];
        int          f0, idx, pulses, high_run;
        bit          seen_low, acc, done;
        logic [23:0] got;
        for (int k = 0; k < 3; k++) begin
            a[k]  = 13'($urandom_range(0, 8191));
            dt[k] = 8'($urandom_range(0, 255));
            // Next command is accepted in the idle cycle after CSB_GAP, so csb stays high one extra cycle
            if (k > 0) exp_gap.push_back(CSB_GAP + 1);
            exp_fr.push_back({1'b0, 2'b00, a[k], dt[k]});
            if (AUTO && a[k] != 13'h0FF) begin
                exp_gap.push_back(CSB_GAP);
                exp_fr.push_back(24'h00FF01);
            end
        end
        read_mode[0] = 1'b0;
        wait_ready(0, "b2b");
        f0 = frame_cnt[0];
        idx = 0; pulses = 0; high_run = 0; seen_low = 1'b0; done = 1'b0;
        cmd_rw[0] = 1'b0; cmd_addr[0] = a[0]; cmd_wdata[0] = dt[0]; cmd_valid[0] = 1'b1;
        for (int c = 0; c < 4000 && !done; c++) begin
            acc = cmd_valid[0] && cmd_ready[0];
            if (csb[0] === 1'b0) begin
                if (seen_low && high_run > 0) obs_gap.push_back(high_run);
                high_run = 0;
                seen_low = 1'b1;
            end else if (seen_low) begin
                high_run++;
            end
            if (rsp_valid[0] === 1'b1) pulses++;
            @(negedge clk);
            if (acc) begin
                idx++;
                if (idx < 3) begin
                    cmd_addr[0]  = a[idx];
                    cmd_wdata[0] = dt[idx];
                end else begin
                    cmd_valid[0] = 1'b0;
                end
            end
            if (idx == 3 && cmd_ready[0] === 1'b1) done = 1'b1;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!done || pulses != 3) begin
            errors++;
            $display("FAIL b2b completion got done=%0d pulses=%0d want 1 3", done, pulses);
        end
        checks++;
        if (frame_cnt[0] - f0 != exp_fr.size()) begin
            errors++;
            $display("FAIL b2b frame_count got %0d want %0d", frame_cnt[0] - f0, exp_fr.size());
        end
        for (int k = 0; k < exp_fr.size(); k++) begin
            got = frame_log[0][3'(f0 + k)];
            checks++;
            if (got !== exp_fr[k]) begin
                errors++;
                $display("FAIL b2b frame%0d got %h want %h", k, got, exp_fr[k]);
            end
        end
        checks++;
        if (obs_gap.size() != exp_gap.size()) begin
            errors++;
            $display("FAIL b2b gap_count got %0d want %0d", obs_gap.size(), exp_gap.size());
        end else begin
            for (int k = 0; k < exp_gap.size(); k++) begin
                checks++;
                if (obs_gap[k] != exp_gap[k]) begin
                    errors++;
                    $display("FAIL b2b csb_high%0d got %0d want %0d", k, obs_gap[k], exp_gap[k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t, pulses;
        read_mode[0] = 1'b0;
        wait_ready(0, "mid_reset");
        cmd_rw[0] = 1'b0;
        cmd_addr[0] = 13'($urandom_range(0, 8191));
        cmd_wdata[0] = 8'($urandom_range(0, 255));
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        t = 0;
        while (rise_cnt[0] < 10 && t < 500) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (rise_cnt[0] < 10) begin
            errors++;
            $display("FAIL mid_reset reach_bit10 got %0d rises want 10", rise_cnt[0]);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (csb[0] !== 1'b1 || sclk[0] !== 1'b0 || sdio_oe[0] !== 1'b0 || rsp_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset async got csb=%b sclk=%b oe=%b rsp=%b want 1 0 0 0",
                     csb[0], sclk[0], sdio_oe[0], rsp_valid[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (rsp_valid[0] !== 1'b0 || csb[0] !== 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset quiet got %0d active cycles want 0", pulses);
        end
        run_cmd(0, 1'b0, 13'h008, 8'h03, 8'h00, "post_reset_write");
    endtask

    task automatic test_clkdiv1();
        run_cmd(1, 1'b1, 13'h1FFF, 8'h00, 8'hA5, "div1_read_1fff");
        run_cmd(1, 1'b0, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)), 8'h00, "div1_write_rand");
        run_cmd(1, 1'b1, 13'($urandom_range(0, 8191)), 8'h00, 8'($urandom_range(0, 255)), "div1_read_rand");
    endtask

    task automatic test_transfer_chain();
        run_cmd(0, 1'b0, 13'h018, 8'h04, 8'h00, "chain_write_018");
        run_cmd(0, 1'b1, 13'h018, 8'h00, 8'($urandom_range(0, 255)), "chain_read_018");
        run_cmd(0, 1'b0, 13'h0FF, 8'h01, 8'h00, "chain_write_0ff");
        run_cmd(1, 1'b0, 13'($urandom_range(0, 8191)), 8'($urandom_range(0, 255)), 8'h00, "chain_div1_write");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cmd_valid[i]  = 1'b0;
            cmd_rw[i]     = 1'b0;
            cmd_addr[i]   = '0;
            cmd_wdata[i]  = '0;
            slave_byte[i] = 8'h00;
            read_mode[i]  = 1'b0;
        end
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv1();
        test_transfer_chain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
